// File: rtl/rf_writeback.sv
// rf_writeback: write-side front end of the register file.
// Buffers ALU / load results in an in-order FIFO, drains one entry per cycle
// into a registered RF write port, and tracks outstanding writes per register.
module rf_writeback #(
  parameter int unsigned DW    = 8,
  parameter int unsigned RFW   = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [RFW-1:0]    alu_rd,
  input  logic [DW-1:0]     alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [RFW-1:0]    mem_rd,
  input  logic [DW-1:0]     mem_data,
  output logic              rf_we,
  output logic [RFW-1:0]    rf_wr_address,
  output logic [DW-1:0]     rf_wr_data,
  output logic [2**RFW-1:0] busy,
  output logic              empty
);

  localparam int unsigned NREG = 2 ** RFW;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned SW   = $clog2(DEPTH + 2);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e         state_q, state_d;
  logic [RFW-1:0] fifo_rd_q   [DEPTH];
  logic [DW-1:0]  fifo_data_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [RFW-1:0] addr_q;
  logic [DW-1:0]  data_q;
  logic [SW-1:0]  pend_q [NREG];
  logic [SW-1:0]  pend_d [NREG];

  logic           full, push, pop;
  logic [RFW-1:0] push_rd, head_rd;
  logic [DW-1:0]  push_data, head_data;

  // Acceptance: loads win over ALU results; readiness ignores same-cycle pops.
  assign full      = (count_q == CW'(DEPTH));
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_rd   = mem_valid ? mem_rd   : alu_rd;
  assign push_data = mem_valid ? mem_data : alu_data;
  assign pop       = (count_q != '0);
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // FIFO storage: written at the tail on accept; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= push_rd;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // FIFO pointers and occupancy; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Drain FSM next state: WRITE only when a non-r0 head is popped.
  always_comb begin
    state_d = IDLE;
    if (pop && (head_rd != '0)) state_d = WRITE;
  end

  // Drain FSM state register; its WRITE state is the registered write enable.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // RF address/data register: loads the head on pop, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (pop) begin
      addr_q <= head_rd;
      data_q <= head_data;
    end
  end

  assign rf_we         = (state_q == WRITE);
  assign rf_wr_address = addr_q;
  assign rf_wr_data    = data_q;
  assign empty         = (count_q == '0) && !rf_we;

  // Pending counters: +1 on accept of a non-r0 write, -1 as its write cycle ends.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (push && (push_rd == RFW'(r)) && (r != 0)) pend_d[r] = pend_d[r] + SW'(1);
      if (rf_we && (addr_q == RFW'(r)))             pend_d[r] = pend_d[r] - SW'(1);
    end
  end

  // Pending counter registers.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rst) pend_q[r] <= '0;
      else     pend_q[r] <= pend_d[r];
    end
  end

  // Busy flags derived from the pending counters.
  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NREG; r++) busy[r] = (pend_q[r] != '0);
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Testbench for rf_writeback: directed scenarios plus a randomized phase,
// checked against a queue-based reference model of the writeback path.
module tb_rf_writeback;

  localparam int DW    = 8;
  localparam int RFW   = 2;
  localparam int DEPTH = 2;
  localparam int NREG  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid;
  logic            alu_ready, mem_ready;
  logic [RFW-1:0]  alu_rd, mem_rd;
  logic [DW-1:0]   alu_data, mem_data;
  logic            rf_we;
  logic [RFW-1:0]  rf_wr_address;
  logic [DW-1:0]   rf_wr_data;
  logic [NREG-1:0] busy;
  logic            empty;

  rf_writeback #(.DW(DW), .RFW(RFW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_wr_address(rf_wr_address), .rf_wr_data(rf_wr_data),
    .busy(busy), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RFW-1:0] rd;
    logic [DW-1:0]  data;
  } entry_t;

  // Reference model: queued entries plus the result currently on the RF port.
  entry_t         mq[$];
  logic           m_we;
  logic [RFW-1:0] m_addr;
  logic [DW-1:0]  m_data;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Busy reflects any queued write to r or a write to r on the port right now.
  task automatic check_outputs(input string tag);
    logic [NREG-1:0] eb;
    eb = '0;
    foreach (mq[i]) if (mq[i].rd != 0) eb[mq[i].rd] = 1'b1;
    if (m_we) eb[m_addr] = 1'b1;
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(m_we));
    chk({tag, ".addr"},  32'(rf_wr_address), 32'(m_addr));
    chk({tag, ".data"},  32'(rf_wr_data), 32'(m_data));
    chk({tag, ".busy"},  32'(busy), 32'(eb));
    chk({tag, ".empty"}, 32'(empty), 32'((mq.size() == 0) && !m_we));
  endtask

  // One clock cycle: drive inputs, check readiness, advance model, check outputs.
  task automatic cycle(input string tag,
                       input logic av, input logic [RFW-1:0] ard, input logic [DW-1:0] ad,
                       input logic mv, input logic [RFW-1:0] mrd, input logic [DW-1:0] md);
    logic   room, acc;
    entry_t e;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    room = (mq.size() < DEPTH);
    chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(room));
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(room && !mv));
    acc = room && (mv || av);
    e.rd   = mv ? mrd : ard;
    e.data = mv ? md  : ad;
    @(posedge clk);
    #1;
    if (mq.size() > 0) begin
      entry_t h;
      h = mq.pop_front();
      m_we = (h.rd != 0);
      m_addr = h.rd;
      m_data = h.data;
    end else begin
      m_we = 1'b0;
    end
    if (acc) mq.push_back(e);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0;
    check_outputs(tag);
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'd1);
    chk({tag, ".mem_ready"}, 32'(mem_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    m_we = 1'b0; m_addr = '0; m_data = '0;
    @(posedge clk);
    do_reset("reset");

    // 1: single ALU result, written two edges after being presented.
    cycle("t1.push", 1'b1, 2'd1, 8'h3C, 1'b0, '0, '0);
    chk("t1.busy_after_accept", 32'(busy[1]), 32'd1);
    chk("t1.we_not_yet", 32'(rf_we), 32'd0);
    idle("t1.w");
    chk("t1.we_const", 32'(rf_we), 32'd1);
    chk("t1.addr_const", 32'(rf_wr_address), 32'd1);
    chk("t1.data_const", 32'(rf_wr_data), 32'h3C);
    idle("t1.d");
    chk("t1.busy_clear", 32'(busy), 32'd0);

    // 2: both valid; load wins, then ALU retries.
    cycle("t2.both", 1'b1, 2'd2, 8'h11, 1'b1, 2'd3, 8'h22);
    cycle("t2.alu",  1'b1, 2'd2, 8'h11, 1'b0, '0, '0);
    idle("t2.d0");
    idle("t2.d1");

    // 3: back-to-back loads, r1 twice.
    cycle("t3.a", 1'b0, '0, '0, 1'b1, 2'd1, 8'hA1);
    cycle("t3.b", 1'b0, '0, '0, 1'b1, 2'd2, 8'hA2);
    cycle("t3.c", 1'b0, '0, '0, 1'b1, 2'd3, 8'hA3);
    cycle("t3.d", 1'b0, '0, '0, 1'b1, 2'd1, 8'hA4);
    idle("t3.d0");
    idle("t3.d1");
    idle("t3.d2");

    // 4: write to r0 is consumed but never reaches the RF.
    cycle("t4.r0", 1'b1, 2'd0, 8'hFF, 1'b0, '0, '0);
    idle("t4.d0");
    idle("t4.d1");

    // 5: ALU held valid over 3*DEPTH pushes.
    for (int i = 0; i < 3 * DEPTH; i++)
      cycle("t5.push", 1'b1, RFW'(i % NREG), DW'(8'h50 + i), 1'b0, '0, '0);
    idle("t5.d0");
    idle("t5.d1");

    // 6: reset while writes are in flight.
    cycle("t6.a", 1'b0, '0, '0, 1'b1, 2'd2, 8'hB2);
    cycle("t6.b", 1'b1, 2'd3, 8'hB3, 1'b0, '0, '0);
    do_reset("t6.rst");
    idle("t6.after0");
    idle("t6.after1");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic av, mv;
      av = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 2) == 0);
      cycle("rand", av, RFW'($urandom), DW'($urandom), mv, RFW'($urandom), DW'($urandom));
    end
    for (int i = 0; i < 4; i++) idle("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
